// File: rtl/qe_pkg.sv
// Shared types and Gray-state helpers for the quadrature generator.
// State order (i,q) 00 -> 10 -> 11 -> 01 matches the decoder's +1 direction.
package qe_pkg;

  localparam int W_DEF  = 16;
  localparam int PW_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } qe_state_t;

  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_10 = 2'b10;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_01 = 2'b01;

  function automatic logic [1:0] qe_next_fwd(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      QS_00:   n = QS_10;
      QS_10:   n = QS_11;
      QS_11:   n = QS_01;
      default: n = QS_00;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] qe_next_rev(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      QS_00:   n = QS_01;
      QS_01:   n = QS_11;
      QS_11:   n = QS_10;
      default: n = QS_00;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/qe_step_timer.sv
// Step-period down-counter; tick is high for the single cycle before expiry
// so the step lands exactly P edges after a reload.
module qe_step_timer
  import qe_pkg::*;
#(
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          clear,
  input  logic          reload,
  input  logic [PW-1:0] period,
  output logic          tick
);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (reload) begin
      cnt <= (period == '0) ? PW'(1) : period;
    end else if (cnt != '0) begin
      cnt <= cnt - PW'(1);
    end
  end

  assign tick = (cnt == PW'(1));

endmodule

// File: rtl/qe_gen.sv
// Quadrature encoder generator: walks a Gray-coded i/q pair one state per
// step period until the generated position equals the latched target.
module qe_gen
  import qe_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          zero,
  input  logic          load,
  input  logic [W-1:0]  target,
  input  logic [PW-1:0] period,
  output logic          i,
  output logic          q,
  output logic [W-1:0]  pos,
  output logic          busy,
  output logic          done
);

  qe_state_t    state, state_nx;
  logic [W-1:0] target_r;
  logic         done_pend;
  logic         tick;

  logic [W-1:0] eff_tgt;
  logic [W-1:0] diff;
  logic [W-1:0] pos_step;
  logic         hit;
  logic         step_last;

  logic         step_en;
  logic         reload;
  logic         done_set;
  logic         pend_set;

  // A load in the same cycle retargets before direction is decided.
  assign eff_tgt   = load ? target : target_r;
  assign diff      = eff_tgt - pos;
  assign hit       = (diff == '0);
  assign pos_step  = diff[W-1] ? (pos - W'(1)) : (pos + W'(1));
  assign step_last = (pos_step == eff_tgt);

  qe_step_timer #(.PW(PW)) u_timer (
    .clk    (clk),
    .clr_n  (clr_n),
    .clear  (zero),
    .reload (reload),
    .period (period),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (zero) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (load && !hit) state_nx = RUN;
        RUN: begin
          if (load && hit) begin
            state_nx = IDLE;
          end else if (tick && step_last) begin
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    step_en  = 1'b0;
    reload   = 1'b0;
    done_set = 1'b0;
    pend_set = 1'b0;
    if (!zero) begin
      case (state)
        IDLE: begin
          if (load) begin
            if (hit) pend_set = 1'b1;
            else     reload   = 1'b1;
          end
        end
        RUN: begin
          if (load && hit) begin
            pend_set = 1'b1;
          end else if (tick) begin
            step_en = 1'b1;
            if (step_last) done_set = 1'b1;
            else           reload   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Immediate-match completions report one cycle late through done_pend.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      i         <= 1'b0;
      q         <= 1'b0;
      pos       <= '0;
      target_r  <= '0;
      done      <= 1'b0;
      done_pend <= 1'b0;
    end else if (zero) begin
      i         <= 1'b0;
      q         <= 1'b0;
      pos       <= '0;
      target_r  <= '0;
      done      <= 1'b0;
      done_pend <= 1'b0;
    end else begin
      if (load) target_r <= target;
      if (step_en) begin
        pos    <= pos_step;
        {i, q} <= diff[W-1] ? qe_next_rev({i, q}) : qe_next_fwd({i, q});
      end
      done      <= done_set | done_pend;
      done_pend <= pend_set;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_qe_gen.sv
// Bench for qe_gen: scoreboard of expected steps plus a quadrature decoder model.
module tb_qe_gen;

  typedef struct {
    logic [1:0]  iq;
    logic [15:0] pos;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        zero = 1'b0;
  logic        load = 1'b0;
  logic [15:0] target = '0;
  logic [15:0] period = '0;
  logic        i, q, busy, done;
  logic [15:0] pos;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = -1;
  bit          ign = 1'b1;
  logic [17:0] prev = '0;
  logic [15:0] dec = '0;
  exp_t        exp_q[$];

  qe_gen dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .zero   (zero),
    .load   (load),
    .target (target),
    .period (period),
    .i      (i),
    .q      (q),
    .pos    (pos),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // (i,q) expected for a position, assuming i/q and pos were cleared together.
  function automatic logic [1:0] seq_iq(input logic [15:0] p);
    logic [1:0] tbl [4];
    tbl = '{2'b00, 2'b10, 2'b11, 2'b01};
    return tbl[p[1:0]];
  endfunction

  function automatic int gidx(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    if ({i, q, pos} !== prev) begin
      if (ign) begin
        dec = '0;
      end else begin
        int d;
        d = (gidx({i, q}) - gidx(prev[17:16]) + 4) % 4;
        if (d == 1) dec = dec + 16'd1;
        else if (d == 3) dec = dec - 16'd1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_step: iq=%b pos=%h cyc=%0d, no step expected", {i, q}, pos, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({i, q} !== e.iq || pos !== e.pos || cyc !== e.cyc) begin
            errors++;
            $display("FAIL step: got iq=%b pos=%h cyc=%0d, want iq=%b pos=%h cyc=%0d",
                     {i, q}, pos, cyc, e.iq, e.pos, e.cyc);
          end
        end
      end
      prev = {i, q, pos};
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic drive_load(input logic [15:0] tgt, output int t);
    load = 1'b1;
    target = tgt;
    @(posedge clk);
    #1;
    t = cyc;
    load = 1'b0;
  endtask

  task automatic push_run(input logic [15:0] p0, input int dir, input int n, input int t0, input int p);
    for (int k = 1; k <= n; k++) begin
      exp_t e;
      e.pos = p0 + 16'(dir * k);
      e.iq  = seq_iq(e.pos);
      e.cyc = t0 + k * p;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input int start, input int budget);
    int n;
    n = 0;
    while (done_cnt == start && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (done_cnt == start) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_zero();
    ign = 1'b1;
    @(posedge clk);
    #2;
    zero = 1'b1;
    @(posedge clk);
    #2;
    zero = 1'b0;
    ign = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({i, q, pos, busy, done} !== 19'd0) begin
      errors++;
      $display("FAIL reset_state: got i=%b q=%b pos=%h busy=%b done=%b, want all 0", i, q, pos, busy, done);
    end
    clr_n = 1'b1;
    @(posedge clk);
    #2;
    ign = 1'b0;
  endtask

  task automatic test_fwd5();
    int t, d0;
    d0 = done_cnt;
    period = 16'd3;
    drive_load(16'd5, t);
    push_run(16'd0, 1, 5, t, 3);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL fwd_busy: got %b want 1", busy);
    end
    wait_done(d0, 60);
    checks++;
    if (pos !== 16'd5 || dec !== 16'd5 || busy !== 1'b0 || done_cyc !== t + 15 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL fwd_end: pos=%h dec=%h busy=%b done_cyc=%0d left=%0d, want 5 5 0 %0d 0",
               pos, dec, busy, done_cyc, exp_q.size(), t + 15);
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL fwd_done_count: got %0d want 1", done_cnt - d0);
    end
  endtask

  task automatic test_reverse();
    int t, d0;
    do_zero();
    d0 = done_cnt;
    period = 16'd1;
    drive_load(16'hFFFE, t);
    push_run(16'd0, -1, 2, t, 1);
    wait_done(d0, 20);
    checks++;
    if (pos !== 16'hFFFE || dec !== 16'hFFFE || {i, q} !== 2'b11 || done_cyc !== t + 2) begin
      errors++;
      $display("FAIL rev_end: pos=%h dec=%h iq=%b done_cyc=%0d, want FFFE FFFE 11 %0d",
               pos, dec, {i, q}, done_cyc, t + 2);
    end
  endtask

  task automatic test_retarget();
    int t, t2, d0;
    do_zero();
    d0 = done_cnt;
    period = 16'd2;
    drive_load(16'd10, t);
    push_run(16'd0, 1, 4, t, 2);
    wait_until(t + 8);
    drive_load(16'd2, t2);
    push_run(16'd4, -1, 2, t, 2);
    exp_q[exp_q.size() - 2].cyc = t + 10;
    exp_q[exp_q.size() - 1].cyc = t + 12;
    wait_done(d0, 40);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (pos !== 16'd2 || dec !== 16'd2 || done_cyc !== t + 12 || done_cnt - d0 != 1 || t2 != t + 9) begin
      errors++;
      $display("FAIL retarget_end: pos=%h dec=%h done_cyc=%0d dones=%0d, want 2 2 %0d 1",
               pos, dec, done_cyc, done_cnt - d0, t + 12);
    end
  endtask

  task automatic test_equal();
    int t, d0;
    d0 = done_cnt;
    drive_load(16'd2, t);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL equal_t0: busy=%b done=%b, want 0 0", busy, done);
    end
    @(posedge clk);
    #2;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL equal_t1: done=%b busy=%b, want 1 0", done, busy);
    end
    @(posedge clk);
    #2;
    checks++;
    if (done !== 1'b0 || done_cnt - d0 != 1 || pos !== 16'd2) begin
      errors++;
      $display("FAIL equal_t2: done=%b dones=%0d pos=%h, want 0 1 0002", done, done_cnt - d0, pos);
    end
  endtask

  task automatic test_zero_load();
    int t, d0;
    period = 16'd4;
    drive_load(16'd100, t);
    push_run(16'd2, 1, 2, t, 4);
    wait_until(t + 9);
    d0 = done_cnt;
    ign = 1'b1;
    zero = 1'b1;
    load = 1'b1;
    target = 16'd50;
    @(posedge clk);
    #2;
    zero = 1'b0;
    load = 1'b0;
    checks++;
    if ({i, q, pos, busy, done} !== 19'd0) begin
      errors++;
      $display("FAIL zero_load: i=%b q=%b pos=%h busy=%b done=%b, want all 0", i, q, pos, busy, done);
    end
    ign = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    checks++;
    if (done_cnt != d0 || pos !== 16'd0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL zero_quiet: dones=%0d pos=%h left=%0d, want 0 0000 0", done_cnt - d0, pos, exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    int t, d0;
    period = 16'd4;
    drive_load(16'd7, t);
    push_run(16'd0, 1, 1, t, 4);
    wait_until(t + 5);
    d0 = done_cnt;
    ign = 1'b1;
    #3;
    clr_n = 1'b0;
    #1;
    checks++;
    if ({i, q, pos, busy, done} !== 19'd0) begin
      errors++;
      $display("FAIL async_reset: i=%b q=%b pos=%h busy=%b done=%b, want all 0", i, q, pos, busy, done);
    end
    repeat (2) @(posedge clk);
    #3;
    clr_n = 1'b1;
    @(posedge clk);
    #2;
    ign = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    checks++;
    if (done_cnt != d0 || pos !== 16'd0 || busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_quiet: dones=%0d pos=%h busy=%b left=%0d, want 0 0000 0 0",
               done_cnt - d0, pos, busy, exp_q.size());
    end
  endtask

  task automatic test_period0();
    int t, d0;
    do_zero();
    d0 = done_cnt;
    period = 16'd0;
    drive_load(16'd3, t);
    push_run(16'd0, 1, 3, t, 1);
    wait_done(d0, 20);
    checks++;
    if (pos !== 16'd3 || dec !== 16'd3 || done_cyc !== t + 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL period0_end: pos=%h dec=%h done_cyc=%0d left=%0d, want 3 3 %0d 0",
               pos, dec, done_cyc, exp_q.size(), t + 3);
    end
  endtask

  initial begin
    test_reset();
    test_fwd5();
    test_reverse();
    test_retarget();
    test_equal();
    test_zero_load();
    test_async_reset();
    test_period0();
    repeat (2) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
